// File: rtl/sample_player_if.sv
// Sample-memory read port: single outstanding word read with a req/ack handshake.
// The player drives the master side; the memory (or its model) drives the slave side.
interface sample_player_if;
  logic        mem_req;
  logic [26:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/sample_player.sv
// Queues sample start addresses from `play` strobes and streams each sample, one
// 16-bit word per audio tick, fetched from sample memory until an end marker or the word cap.
module sample_player #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_WORDS  = 2**20,
  parameter logic [15:0] END_MARKER = 16'h8000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic [26:0]            address_in,
  input  logic                   sample_tick,
  sample_player_if.master        mem,
  output logic [15:0]            audio_out,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [26:0]   fifo_q [DEPTH];
  logic [26:0]   fifo_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [26:0]   addr_q, addr_d;
  logic [15:0]   word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic [15:0]   audio_q, audio_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          have_next_s;

  // Start-address queue: a push is accepted when full only if LOAD frees a slot the same cycle.
  always_comb begin
    full_s     = (count_q == CNT_FULL);
    pop_s      = (state_q == LOAD);
    push_s     = play && (!full_s || pop_s);
    overflow_d = play && full_s && !pop_s;
    fifo_d     = fifo_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = address_in;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Playback FSM; a pending push counts as queued so an idle block starts without a wasted cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    audio_d     = audio_q;
    have_next_s = (count_q != (AW+1)'(0)) || push_s;
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (sample_tick && (count_q == (AW+1)'(0))) begin
          audio_d = 16'h0000;
        end else begin
          audio_d = audio_q;
        end
        if (have_next_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        addr_d    = fifo_q[rd_ptr_q];
        cnt_d     = CW'(0);
        mem_req_d = 1'b1;
        state_d   = FETCH;
      end
      FETCH: begin
        if (mem.mem_ack) begin
          word_d    = mem.mem_data;
          mem_req_d = 1'b0;
          if (mem.mem_data == END_MARKER) begin
            state_d = have_next_s ? LOAD : IDLE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          mem_req_d = 1'b1;
          state_d   = FETCH;
        end
      end
      HOLD: begin
        if (sample_tick) begin
          audio_d = word_q;
          addr_d  = addr_q + 27'd1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_d == CNT_MAX) begin
            state_d   = have_next_s ? LOAD : IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d   = FETCH;
            mem_req_d = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE) || (count_d != (AW+1)'(0));
  end

  // Control and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= 27'd0;
      word_q     <= 16'h0000;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      audio_q    <= 16'h0000;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      audio_q    <= audio_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Queue storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = addr_q;
  assign audio_out    = audio_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: a vector table of single-sample cases plus hand-written
// sequences for bursts, queue overflow, tick/ack collision, the word cap and mid-transfer reset.
module tb_sample_player;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        play4 = 1'b0;
  logic [26:0] address_in = 27'd0;
  logic [26:0] address_in4 = 27'd0;
  logic        auto_tick = 1'b0;
  logic        man_tick = 1'b0;
  logic        tick_en = 1'b0;
  logic        sample_tick;
  logic [15:0] audio_out, audio_out4;
  logic        busy, busy4, overflow, overflow4;

  assign sample_tick = auto_tick | man_tick;

  always #5 clk = ~clk;

  sample_player_if mem_if ();
  sample_player_if mem_if4 ();

  sample_player u_dut (
    .clk(clk), .reset(reset), .play(play), .address_in(address_in),
    .sample_tick(sample_tick), .mem(mem_if), .audio_out(audio_out),
    .busy(busy), .overflow(overflow)
  );

  sample_player #(.MAX_WORDS(4)) u_dut4 (
    .clk(clk), .reset(reset), .play(play4), .address_in(address_in4),
    .sample_tick(sample_tick), .mem(mem_if4), .audio_out(audio_out4),
    .busy(busy4), .overflow(overflow4)
  );

  typedef struct {
    logic [26:0]      addr;
    int               n;
    logic [2:0][15:0] w;    // w[0] is the first word played
    int               lat;  // 0 = random 1..10 cycles
  } vec_t;

  vec_t        vecs [5];
  int          checks = 0;
  int          failures = 0;
  int          lat_mode = 1;
  int          tick_cnt = 0;
  int          ov_count = 0;
  int          marker_seen = 0;
  int          found;
  logic [15:0] mem_model [logic [26:0]];
  logic [15:0] log_q [$];
  logic [15:0] log4_q [$];
  logic [15:0] exp_q [$];
  logic [26:0] rlog4_q [$];
  logic [26:0] exp_a [6];
  logic [15:0] last_a = 16'h0000;
  logic [15:0] last_b = 16'h0000;
  logic        r_pend = 1'b0;
  int          r_cnt = 0;
  logic [26:0] r_start = 27'd0;
  logic        r_chg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [26:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    else return 16'h8000;
  endfunction

  task automatic load(input logic [26:0] a, input int n, input logic [2:0][15:0] w);
    logic [26:0] k;
    for (int i = 0; i < n; i++) begin
      k = a + 27'(i);
      mem_model[k] = w[i];
    end
    k = a + 27'(n);
    mem_model[k] = 16'h8000;
  endtask

  task automatic check_log(input bit which, input string name);
    int act_n;
    act_n = which ? log4_q.size() : log_q.size();
    chk({name, "_len"}, act_n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_n) chk($sformatf("%s[%0d]", name, i), which ? log4_q[i] : log_q[i], exp_q[i]);
    end
  endtask

  task automatic wait_idle(input bit which, input string name);
    int n;
    n = 0;
    while ((which ? busy4 : busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, which ? busy4 : busy, 1'b0);
  endtask

  // Play one address on the main DUT and check the two-cycle request latency.
  task automatic play1(input logic [26:0] a, input string name);
    @(negedge clk);
    play = 1'b1;
    address_in = a;
    @(negedge clk);
    play = 1'b0;
    chk({name, "_req_c1"}, mem_if.mem_req, 1'b0);
    chk({name, "_busy_c1"}, busy, 1'b1);
    @(negedge clk);
    chk({name, "_req_c2"}, mem_if.mem_req, 1'b1);
    chk({name, "_addr_c2"}, mem_if.mem_addr, a);
  endtask

  // Tick generator: one pulse every 20 clocks while enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_en && tick_cnt >= 19) begin
        auto_tick = 1'b1;
        tick_cnt = 0;
      end else begin
        auto_tick = 1'b0;
        if (tick_en) tick_cnt++;
      end
    end
  end

  // Memory model for the main DUT: latches the request, acks after lat_mode cycles.
  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_if.mem_ack) begin
        mem_if.mem_ack = 1'b0;
      end else begin
        if (!r_pend && mem_if.mem_req) begin
          r_pend = 1'b1;
          r_start = mem_if.mem_addr;
          r_chg = 1'b0;
          r_cnt = (lat_mode == 0) ? int'($urandom_range(1, 10)) : lat_mode;
        end
        if (r_pend) begin
          if (mem_if.mem_req && mem_if.mem_addr != r_start) r_chg = 1'b1;
          if (r_cnt <= 1) begin
            mem_if.mem_ack = 1'b1;
            mem_if.mem_data = rd(r_start);
            r_pend = 1'b0;
            chk("mem_addr_stable", r_chg, 1'b0);
          end else begin
            r_cnt--;
          end
        end
      end
    end
  end

  // Memory model for the capped DUT: single-cycle ack, logs every address read.
  initial begin
    mem_if4.mem_ack = 1'b0;
    mem_if4.mem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_if4.mem_ack) begin
        mem_if4.mem_ack = 1'b0;
      end else if (mem_if4.mem_req) begin
        mem_if4.mem_ack = 1'b1;
        mem_if4.mem_data = rd(mem_if4.mem_addr);
        rlog4_q.push_back(mem_if4.mem_addr);
      end
    end
  end

  // Output monitors: record each change of audio_out and count overflow pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (audio_out != last_a) begin
        log_q.push_back(audio_out);
        last_a = audio_out;
      end
      if (audio_out4 != last_b) begin
        log4_q.push_back(audio_out4);
        last_b = audio_out4;
      end
      if (audio_out == 16'h8000 || audio_out4 == 16'h8000) marker_seen++;
      if (overflow) ov_count++;
    end
  end

  initial begin
    vecs[0] = '{27'h0000100, 3, {16'h0003, 16'h0002, 16'h0001}, 1};
    vecs[1] = '{27'h0002000, 3, {16'h1234, 16'h8001, 16'h7FFF}, 0};
    vecs[2] = '{27'h0000055, 1, {16'h0000, 16'h0000, 16'hFFFF}, 0};
    vecs[3] = '{27'h7FFFFFE, 3, {16'h00A3, 16'h00A2, 16'h00A1}, 0};
    vecs[4] = '{27'h0000300, 0, {16'h0000, 16'h0000, 16'h0000}, 0};

    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_if.mem_req, 1'b0);
    chk("rst_mem_addr", mem_if.mem_addr, 27'd0);
    chk("rst_audio", audio_out, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    tick_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].addr, vecs[v].n, vecs[v].w);
      lat_mode = vecs[v].lat;
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].w[i]);
      if (vecs[v].n > 0) exp_q.push_back(16'h0000);
      log_q.delete();
      play1(vecs[v].addr, $sformatf("vec%0d", v));
      wait_idle(1'b0, $sformatf("vec%0d_idle", v));
      repeat (25) @(negedge clk);
      check_log(1'b0, $sformatf("vec%0d_audio", v));
    end

    // Burst of three plays on consecutive cycles.
    load(27'h100, 2, {16'h0000, 16'h000B, 16'h000A});
    load(27'h200, 2, {16'h0000, 16'h0015, 16'h0014});
    load(27'h300, 2, {16'h0000, 16'h001F, 16'h001E});
    lat_mode = 0;
    ov_count = 0;
    log_q.delete();
    exp_q = '{16'h000A, 16'h000B, 16'h0014, 16'h0015, 16'h001E, 16'h001F, 16'h0000};
    @(negedge clk); play = 1'b1; address_in = 27'h100;
    @(negedge clk); address_in = 27'h200;
    @(negedge clk); address_in = 27'h300;
    @(negedge clk); play = 1'b0;
    wait_idle(1'b0, "burst_idle");
    repeat (25) @(negedge clk);
    check_log(1'b0, "burst_audio");
    chk("burst_no_overflow", ov_count, 0);

    // Seventeen plays while the current sample waits in HOLD.
    tick_en = 1'b0;
    lat_mode = 2;
    load(27'h400, 1, {16'h0000, 16'h0000, 16'h0040});
    exp_q = '{16'h0040};
    for (int i = 0; i < 17; i++) begin
      load(27'h1000 + 27'(i * 16), 1, {16'h0000, 16'h0000, 16'h0100 + 16'(i)});
      if (i < 16) exp_q.push_back(16'h0100 + 16'(i));
    end
    exp_q.push_back(16'h0000);
    log_q.delete();
    play1(27'h400, "ovf_first");
    repeat (30) @(negedge clk);
    chk("ovf_hold_req", mem_if.mem_req, 1'b0);
    chk("ovf_hold_busy", busy, 1'b1);
    ov_count = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("ovf_low_before", overflow, 1'b0);
      play = 1'b1;
      address_in = 27'h1000 + 27'(i * 16);
    end
    @(negedge clk);
    play = 1'b0;
    chk("ovf_on_17th", overflow, 1'b1);
    @(negedge clk);
    chk("ovf_one_cycle", overflow, 1'b0);
    tick_en = 1'b1;
    wait_idle(1'b0, "ovf_idle");
    repeat (25) @(negedge clk);
    check_log(1'b0, "ovf_audio");
    chk("ovf_pulse_count", ov_count, 1);

    // Tick coincident with ack is missed; the word waits for the next tick.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    lat_mode = 4;
    load(27'h500, 2, {16'h0000, 16'h0052, 16'h0051});
    exp_q = '{16'h0051, 16'h0052, 16'h0000};
    log_q.delete();
    play1(27'h500, "coinc");
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (mem_if.mem_ack) begin
        found = 1;
        break;
      end
    end
    chk("coinc_ack_seen", found, 1);
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    chk("coinc_tick_missed", audio_out, 16'h0000);
    repeat (3) @(negedge clk);
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    chk("coinc_next_tick", audio_out, 16'h0051);
    tick_en = 1'b1;
    wait_idle(1'b0, "coinc_idle");
    repeat (25) @(negedge clk);
    check_log(1'b0, "coinc_audio");

    // Word cap of 4 on a marker-less sample starting at the top of the address space.
    mem_model[27'h7FFFFFE] = 16'h0011;
    mem_model[27'h7FFFFFF] = 16'h0022;
    mem_model[27'h0000000] = 16'h0033;
    mem_model[27'h0000001] = 16'h0044;
    mem_model[27'h0000002] = 16'h0055;
    load(27'h600, 1, {16'h0000, 16'h0000, 16'h0066});
    log4_q.delete();
    rlog4_q.delete();
    exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0066, 16'h0000};
    exp_a = '{27'h7FFFFFE, 27'h7FFFFFF, 27'h0000000, 27'h0000001, 27'h0000600, 27'h0000601};
    @(negedge clk); play4 = 1'b1; address_in4 = 27'h7FFFFFE;
    @(negedge clk); address_in4 = 27'h600;
    @(negedge clk); play4 = 1'b0;
    wait_idle(1'b1, "cap_idle");
    repeat (25) @(negedge clk);
    check_log(1'b1, "cap_audio");
    chk("cap_reads_len", rlog4_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rlog4_q.size()) chk($sformatf("cap_read[%0d]", i), rlog4_q[i], exp_a[i]);
    end

    // Reset while a request is outstanding with two entries queued.
    lat_mode = 2;
    load(27'h700, 1, {16'h0000, 16'h0000, 16'h0077});
    play1(27'h700, "pre_rst");
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (audio_out == 16'h0077) begin
        found = 1;
        break;
      end
    end
    chk("pre_rst_audio", found, 1);
    tick_en = 1'b0;
    repeat (12) @(negedge clk);
    lat_mode = 10;
    load(27'h710, 1, {16'h0000, 16'h0000, 16'h0071});
    load(27'h720, 1, {16'h0000, 16'h0000, 16'h0072});
    load(27'h730, 1, {16'h0000, 16'h0000, 16'h0073});
    @(negedge clk); play = 1'b1; address_in = 27'h710;
    @(negedge clk); address_in = 27'h720;
    @(negedge clk); address_in = 27'h730;
    @(negedge clk); play = 1'b0;
    chk("rst_mid_req_high", mem_if.mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_req", mem_if.mem_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_audio", audio_out, 16'h0000);
    repeat (15) @(negedge clk);
    chk("late_ack_req", mem_if.mem_req, 1'b0);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_audio", audio_out, 16'h0000);
    lat_mode = 2;
    tick_en = 1'b1;
    load(27'h740, 1, {16'h0000, 16'h0000, 16'h0074});
    log_q.delete();
    exp_q = '{16'h0074, 16'h0000};
    play1(27'h740, "post_rst");
    wait_idle(1'b0, "post_rst_idle");
    repeat (25) @(negedge clk);
    check_log(1'b0, "post_rst_audio");

    chk("marker_never_out", marker_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
